// File: rtl/ahb_sim_ctrl_if.sv
// AHB-Lite bus bundle between the system-bus master and the simulation-control slave.
// Latency: none (wires only).
// Backpressure: the slave drives HREADYOUT; the master feeds the bus-level HREADY back in.
//
// Signals: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY from master, HREADYOUT/HRDATA/HRESP from slave.
interface ahb_sim_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [31:0]       HRDATA;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_sim_ctrl.sv
// AHB-Lite simulation-control slave: exit mailbox, console byte FIFO, free-running cycle counter.
// Latency: zero-wait-state reads/writes; errors take two cycles (ERR1 wait, ERR2 complete).
// Backpressure: a PUTC into a full FIFO holds HREADYOUT low until a slot frees (a same-cycle pop counts).
//
// Ports: HCLK, HRESET (async, active-high); bus (AHB slave modport);
//   char_valid_o/char_data_o/char_ready_i console stream; exit_valid_o/exit_value_o/
//   tests_passed_o/tests_failed_o exit mailbox status.
// Registers (HADDR[3:2]): 0 EXIT W/R, 1 PUTC W (reads 0), 2 CYCLE R, 3 STATUS R.
module ahb_sim_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         HCLK,
  input  logic         HRESET,
  ahb_sim_ctrl_if.slave bus,
  output logic         char_valid_o,
  output logic [7:0]   char_data_o,
  input  logic         char_ready_i,
  output logic         exit_valid_o,
  output logic [31:0]  exit_value_o,
  output logic         tests_passed_o,
  output logic         tests_failed_o
);

  localparam int         PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [2:0] SZ_BYTE    = 3'b000;
  localparam logic [2:0] SZ_WORD    = 3'b010;
  localparam logic [1:0] OFF_EXIT   = 2'd0;
  localparam logic [1:0] OFF_PUTC   = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_STALL, S_ERR1, S_ERR2} state_t;

  state_t      state_q;
  logic        wr_q;
  logic [1:0]  off_q;
  logic        hresp_q;
  logic        exit_valid_q;
  logic [31:0] exit_value_q;
  logic [31:0] cycle_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic        fifo_empty, fifo_full, pop, push;
  logic        putc_pending, hold, hreadyout, accept, a_err;
  logic [1:0]  a_off;
  logic [31:0] status, rdata;
  logic        unused_bus;

  assign unused_bus = ^{bus.HTRANS[0], bus.HADDR};

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && char_ready_i;

  // A PUTC data phase waits while the FIFO is full, unless the consumer
  // frees a slot in this very cycle.
  assign putc_pending = (state_q == S_DATA || state_q == S_STALL) && wr_q && (off_q == OFF_PUTC);
  assign hold         = putc_pending && fifo_full && !pop;
  assign push         = putc_pending && !hold;

  // HREADYOUT must react within the data-phase cycle to FIFO space, so it is
  // decoded from the state register plus the live FIFO condition.
  assign hreadyout = (state_q != S_ERR1) && !hold;
  assign accept    = hreadyout && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign a_off     = bus.HADDR[3:2];
  // Only PUTC takes byte size; any other size (halfword included) errors.
  // CYCLE and STATUS are read-only.
  assign a_err     = ((bus.HSIZE != SZ_WORD) && !((bus.HSIZE == SZ_BYTE) && (a_off == OFF_PUTC)))
                   || (bus.HWRITE && a_off[1]);

  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign tests_passed_o = exit_valid_q && (exit_value_q == 32'd0);
  assign tests_failed_o = exit_valid_q && (exit_value_q != 32'd0);

  assign status = {27'b0, fifo_full, fifo_empty, tests_failed_o, tests_passed_o, exit_valid_o};

  always_comb begin
    rdata = 32'd0;
    if (state_q == S_DATA && !wr_q) begin
      case (off_q)
        OFF_EXIT:   rdata = exit_value_q;
        OFF_CYCLE:  rdata = cycle_q;
        OFF_STATUS: rdata = status;
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = rdata;

  // Bus FSM, exit mailbox and cycle counter.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      off_q        <= 2'd0;
      hresp_q      <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'd0;
      cycle_q      <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_q == S_DATA && wr_q && off_q == OFF_EXIT && !exit_valid_q) begin
        exit_valid_q <= 1'b1;
        exit_value_q <= bus.HWDATA;
      end
      case (state_q)
        S_ERR1: state_q <= S_ERR2;
        default: begin
          if (hold) begin
            state_q <= S_STALL;
          end else if (accept) begin
            wr_q    <= bus.HWRITE;
            off_q   <= a_off;
            hresp_q <= a_err;
            state_q <= a_err ? S_ERR1 : S_DATA;
          end else begin
            hresp_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.HWDATA[7:0];
  end

  assign char_valid_o = !fifo_empty;
  assign char_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ahb_sim_ctrl.sv
// Directed bench for ahb_sim_ctrl: reset, exit mailbox, console FIFO stall/drain, error responses.
// Latency: reads checked in the first data-phase cycle; writes checked for OKAY on completion.
// Backpressure: console consumer held off to force a full-FIFO stall, then released.
module tb_ahb_sim_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_sim_ctrl_if #(.ADDR_W(16)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        exit_valid, passed, failed;
  logic [31:0] exit_value;

  ahb_sim_ctrl #(.ADDR_W(16), .FIFO_DEPTH(16)) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus),
    .char_valid_o(char_valid), .char_data_o(char_data), .char_ready_i(char_ready),
    .exit_valid_o(exit_valid), .exit_value_o(exit_value),
    .tests_passed_o(passed), .tests_failed_o(failed)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tb_cyc  = 0;
  int rel_cyc = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  ch_q [$];
  logic [31:0] r;
  logic [7:0]  ec;
  logic [31:0] c_before;
  bit          released;
  int          seen;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = tb_cyc;
    ch_q.delete();
    rd_q.delete();
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HADDR = a; bus.HTRANS = 2'b10; bus.HWRITE = w; bus.HSIZE = sz;
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = wd;
  endtask

  task automatic finish_dp(input string tag, output logic [31:0] rd);
    bit done;
    done = 1'b0;
    rd = 32'd0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.HREADYOUT === 1'b1) begin
        rd = bus.HRDATA;
        done = 1'b1;
        chk({tag, " resp"}, {31'b0, bus.HRESP}, 32'd0);
      end
      @(posedge clk); #1;
    end
    if (!done) chk({tag, " hreadyout timeout"}, {31'b0, bus.HREADYOUT}, 32'd1);
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] d, input logic [2:0] sz);
    logic [31:0] unused_rd;
    addr_phase(a, 1'b1, sz, d);
    finish_dp(tag, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] got;
    addr_phase(a, 1'b0, 3'b010, 32'd0);
    rd_q.push_back(exp);
    finish_dp(tag, got);
    chk(tag, got, rd_q.pop_front());
  endtask

  // CYCLE counts rising edges since reset release, including the address-phase edge.
  task automatic rd_cycle(input string tag, output logic [31:0] got);
    addr_phase(16'h0008, 1'b0, 3'b010, 32'd0);
    rd_q.push_back(32'(tb_cyc - rel_cyc));
    finish_dp(tag, got);
    chk(tag, got, rd_q.pop_front());
  endtask

  task automatic check_err(input string tag);
    @(negedge clk);
    chk({tag, " err1 rdy"},  {31'b0, bus.HREADYOUT}, 32'd0);
    chk({tag, " err1 resp"}, {31'b0, bus.HRESP},     32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " err2 rdy"},  {31'b0, bus.HREADYOUT}, 32'd1);
    chk({tag, " err2 resp"}, {31'b0, bus.HRESP},     32'd1);
    @(posedge clk); #1;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] c;
      c = 8'h41 + 8'(i);
      ch_q.push_back(c);
      // odd entries go as byte writes with junk in the upper lanes
      if (i % 2 == 1) wr("putc byte", 16'h0004, {24'hA5A5A5, c}, 3'b000);
      else            wr("putc word", 16'h0004, {24'h0, c}, 3'b010);
    end
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = '0;
    char_ready = 1'b0;
    rst = 1'b1;

    // Reset values and cycle counter
    do_reset();
    chk("rst hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("rst hresp",     {31'b0, bus.HRESP},     32'd0);
    chk("rst hrdata",    bus.HRDATA,             32'd0);
    chk("rst exit_valid", {31'b0, exit_valid},   32'd0);
    chk("rst char_valid", {31'b0, char_valid},   32'd0);
    repeat (9) @(posedge clk);
    rd_cycle("cycle after reset", r);

    // EXIT=0 passes, later write ignored
    wr("exit0", 16'h0000, 32'd0, 3'b010);
    @(negedge clk);
    chk("exit_valid after 0", {31'b0, exit_valid}, 32'd1);
    chk("passed after 0",     {31'b0, passed},     32'd1);
    wr("exit5", 16'h0000, 32'd5, 3'b010);
    @(negedge clk);
    chk("exit_value write-once", exit_value,        32'd0);
    chk("failed stays 0",        {31'b0, failed},   32'd0);
    rd_chk("exit readback", 16'h0000, 32'd0);

    // Errors: write to CYCLE leaves counter intact; bad sizes
    rd_cycle("cycle before err", c_before);
    addr_phase(16'h0008, 1'b1, 3'b010, 32'hDEAD_BEEF);
    check_err("wr cycle");
    rd_cycle("cycle after err", r);
    addr_phase(16'h000C, 1'b1, 3'b010, 32'h0);
    check_err("wr status");
    addr_phase(16'h0004, 1'b1, 3'b001, 32'h0000_0058);
    check_err("putc halfword");
    @(negedge clk);
    chk("no push on err", {31'b0, char_valid}, 32'd0);
    addr_phase(16'h0000, 1'b0, 3'b000, 32'h0);
    check_err("exit byte read");
    rd_chk("putc reads 0", 16'h0004, 32'd0);

    // EXIT nonzero -> failed, STATUS = empty|failed|valid
    do_reset();
    wr("exit2a", 16'h0000, 32'h2A, 3'b010);
    @(negedge clk);
    chk("failed after 2a",  {31'b0, failed}, 32'd1);
    chk("passed after 2a",  {31'b0, passed}, 32'd0);
    chk("exit_value 2a",    exit_value,      32'h2A);
    rd_chk("status after 2a", 16'h000C, 32'h0000_000D);

    // FIFO fill, stall on 17th, drain in order
    do_reset();
    fill16();
    @(negedge clk);
    chk("head valid", {31'b0, char_valid}, 32'd1);
    chk("head data",  {24'b0, char_data},  32'h41);
    rd_chk("status full", 16'h100C, 32'h0000_0010);
    addr_phase(16'h0004, 1'b1, 3'b010, 32'h51);
    ch_q.push_back(8'h51);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall hreadyout", {31'b0, bus.HREADYOUT}, 32'd0);
      @(posedge clk); #1;
    end
    char_ready = 1'b1;
    released = 1'b0;
    for (int i = 0; i < 60 && (ch_q.size() != 0 || !released); i++) begin
      @(negedge clk);
      if (bus.HREADYOUT === 1'b1 && !released) begin
        released = 1'b1;
        chk("release on first pop", 32'(ch_q.size()), 32'd17);
        chk("release resp", {31'b0, bus.HRESP}, 32'd0);
      end
      if (char_valid === 1'b1) begin
        if (ch_q.size() == 0) chk("spurious char", {31'b0, char_valid}, 32'd0);
        else begin
          ec = ch_q.pop_front();
          chk("char order", {24'b0, char_data}, {24'b0, ec});
        end
      end
      @(posedge clk); #1;
    end
    chk("drain complete", 32'(ch_q.size()), 32'd0);
    chk("stall released", {31'b0, released}, 32'd1);
    @(negedge clk);
    chk("fifo empty after drain", {31'b0, char_valid}, 32'd0);
    char_ready = 1'b0;

    // Reset during stall drops the pending byte
    do_reset();
    fill16();
    addr_phase(16'h0004, 1'b1, 3'b010, 32'h51);
    @(negedge clk);
    chk("stall before reset", {31'b0, bus.HREADYOUT}, 32'd0);
    rst = 1'b1;
    #1;
    chk("reset frees bus", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("reset empties fifo", {31'b0, char_valid}, 32'd0);
    ch_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = tb_cyc;
    char_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (char_valid !== 1'b0) seen++;
    end
    chk("no char after reset", 32'(seen), 32'd0);
    rd_chk("status after reset", 16'h000C, 32'h0000_0008);
    rd_cycle("cycle after mid-stall reset", r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
